// File: rtl/stage4_message_assemble.sv
`default_nettype none
// ============================================================================
// stage4_message_assemble
// Packs SOP/EOP-framed byte messages into batches of up to three lanes for
// the stage-5 field extractors. Optional macro: STAGE4_FLUSH_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module stage4_message_assemble #(
  parameter int                MAX_MESSAGE_BITS = 512,
  parameter int                CTRL_W           = 4,
  parameter logic [CTRL_W-1:0] MUX_NONE         = CTRL_W'(0),
  parameter logic [CTRL_W-1:0] MUX_K            = CTRL_W'(1),
  parameter logic [CTRL_W-1:0] MUX_A            = CTRL_W'(2),
  parameter logic [CTRL_W-1:0] MUX_E            = CTRL_W'(3),
  parameter int                TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic                        in_last,
  output logic                        message_en,
  output logic [MAX_MESSAGE_BITS-1:0] message_1,
  output logic [MAX_MESSAGE_BITS-1:0] message_2,
  output logic [MAX_MESSAGE_BITS-1:0] message_3,
  output logic [CTRL_W-1:0]           message_mux_control_m1,
  output logic [CTRL_W-1:0]           message_mux_control_m2,
  output logic [CTRL_W-1:0]           message_mux_control_m3,
  output logic                        overflow_err,
  output logic                        framing_err
);

  localparam int         C_NBYTES    = MAX_MESSAGE_BITS / 8;
  localparam int         C_OFF_W     = $clog2(C_NBYTES + 1);
  localparam logic [1:0] C_LAST_LANE = 2'd2;
  localparam logic       S_IDLE      = 1'b0;
  localparam logic       S_FILL      = 1'b1;

  logic                        r_state;
  logic                        w_state_next;
  logic [MAX_MESSAGE_BITS-1:0] r_asm [3];
  logic [CTRL_W-1:0]           r_ctrl [3];
  logic [1:0]                  r_lane;
  logic [C_OFF_W-1:0]          r_off;

  logic                        w_start;
  logic                        w_write;
  logic                        w_framing;
  logic                        w_close_msg;
  logic                        w_close_batch;
  logic                        w_flush;
  logic [C_OFF_W-1:0]          w_off;
  logic [C_OFF_W-1:0]          w_byte_idx;
  logic                        w_byte_ok;
  logic [MAX_MESSAGE_BITS-1:0] w_lane_data;
  logic [CTRL_W-1:0]           w_lane_ctrl;
  logic [MAX_MESSAGE_BITS-1:0] w_emit_msg [3];
  logic [CTRL_W-1:0]           w_emit_ctrl [3];

  function automatic logic [CTRL_W-1:0] decode_type(input logic [7:0] type_byte);
    case (type_byte)
      8'h6B:   decode_type = MUX_K;
      8'h41:   decode_type = MUX_A;
      8'h45:   decode_type = MUX_E;
      default: decode_type = MUX_NONE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid && in_sop && !in_eop) w_state_next = S_FILL;
      S_FILL:  if (in_valid && in_eop) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A sop seen in FILL restarts the same lane and flags a framing error.
  always_comb begin
    w_start   = 1'b0;
    w_write   = 1'b0;
    w_framing = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = in_valid & in_sop;
        w_write = in_valid & in_sop;
      end
      S_FILL: begin
        w_start   = in_valid & in_sop;
        w_write   = in_valid;
        w_framing = in_valid & in_sop;
      end
      default: ;
    endcase
    w_close_msg   = w_write & in_eop;
    w_close_batch = (w_close_msg & (in_last | (r_lane == C_LAST_LANE))) | w_flush;
  end

  // Next content of the active lane, including the byte accepted this cycle.
  always_comb begin
    w_off       = w_start ? '0 : r_off;
    w_byte_ok   = w_write && (w_off < C_OFF_W'(C_NBYTES));
    w_byte_idx  = C_OFF_W'(C_NBYTES - 1) - w_off;
    w_lane_data = w_start ? '0 : r_asm[r_lane];
    if (w_byte_ok) w_lane_data[{w_byte_idx, 3'b000} +: 8] = in_data;
    w_lane_ctrl = w_start ? decode_type(in_data) : r_ctrl[r_lane];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        r_asm[k]  <= '0;
        r_ctrl[k] <= '0;
      end
      r_lane       <= '0;
      r_off        <= '0;
      overflow_err <= 1'b0;
      framing_err  <= 1'b0;
    end else begin
      if (w_write) begin
        r_asm[r_lane]  <= w_lane_data;
        r_ctrl[r_lane] <= w_lane_ctrl;
        r_off          <= w_byte_ok ? w_off + 1'b1 : w_off;
      end
      if (w_write && !w_byte_ok) overflow_err <= 1'b1;
      if (w_framing)             framing_err  <= 1'b1;
      if (w_close_batch)         r_lane <= '0;
      else if (w_close_msg)      r_lane <= r_lane + 2'd1;
    end
  end

  // Lanes beyond the closing one may still hold data from an older batch.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_emit_msg[k]  = '0;
      w_emit_ctrl[k] = MUX_NONE;
      if (2'(k) < r_lane) begin
        w_emit_msg[k]  = r_asm[k];
        w_emit_ctrl[k] = r_ctrl[k];
      end else if ((2'(k) == r_lane) && w_close_msg) begin
        w_emit_msg[k]  = w_lane_data;
        w_emit_ctrl[k] = w_lane_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      message_en             <= 1'b0;
      message_1              <= '0;
      message_2              <= '0;
      message_3              <= '0;
      message_mux_control_m1 <= '0;
      message_mux_control_m2 <= '0;
      message_mux_control_m3 <= '0;
    end else begin
      message_en <= w_close_batch;
      if (w_close_batch) begin
        message_1              <= w_emit_msg[0];
        message_2              <= w_emit_msg[1];
        message_3              <= w_emit_msg[2];
        message_mux_control_m1 <= w_emit_ctrl[0];
        message_mux_control_m2 <= w_emit_ctrl[1];
        message_mux_control_m3 <= w_emit_ctrl[2];
      end
    end
  end

`ifdef STAGE4_FLUSH_TIMEOUT_EN
  localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [C_CNT_W-1:0] r_idle_cnt;
  logic               w_idle_tick;

  assign w_idle_tick = !in_valid && (r_state == S_IDLE) && (r_lane != 2'd0);
  assign w_flush     = w_idle_tick && (r_idle_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_idle_cnt <= '0;
    else if (in_valid || w_flush) r_idle_cnt <= '0;
    else if (w_idle_tick)         r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_flush          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage4_message_assemble.sv
`default_nettype none
// ============================================================================
// tb_stage4_message_assemble
// Random and directed byte streams against a queue-based batch model.
// Revision: 1.0
// ============================================================================
module tb_stage4_message_assemble;

  localparam int MB  = 512;
  localparam int NB  = MB / 8;
  localparam int CW  = 4;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_last = 1'b0;
  logic          message_en;
  logic [MB-1:0] message_1, message_2, message_3;
  logic [CW-1:0] message_mux_control_m1, message_mux_control_m2, message_mux_control_m3;
  logic          overflow_err, framing_err;

  stage4_message_assemble dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_valid               (in_valid),
    .in_data                (in_data),
    .in_sop                 (in_sop),
    .in_eop                 (in_eop),
    .in_last                (in_last),
    .message_en             (message_en),
    .message_1              (message_1),
    .message_2              (message_2),
    .message_3              (message_3),
    .message_mux_control_m1 (message_mux_control_m1),
    .message_mux_control_m2 (message_mux_control_m2),
    .message_mux_control_m3 (message_mux_control_m3),
    .overflow_err           (overflow_err),
    .framing_err            (framing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][MB-1:0] m;
    logic [2:0][CW-1:0] c;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  // Reference model: messages as byte lists, batches as lists of messages.
  bit                 m_in_msg;
  logic [7:0]         m_cur[$];
  logic [2:0][MB-1:0] m_bm;
  logic [2:0][CW-1:0] m_bc;
  int                 m_bn;
  bit                 m_ovf, m_frm;
  int                 m_idle;

  function automatic logic [CW-1:0] exp_code(input logic [7:0] t);
    case (t)
      8'h6B:   return 4'd1;
      8'h41:   return 4'd2;
      8'h45:   return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_in_msg = 0; m_cur.delete(); m_bm = '0; m_bc = '0; m_bn = 0;
    m_ovf = 0; m_frm = 0; m_idle = 0; exp_q.delete();
  endtask

  task automatic model_emit();
    exp_t e;
    e.m = m_bm; e.c = m_bc; e.cyc = cyc + 1;
    exp_q.push_back(e);
    m_bm = '0; m_bc = '0; m_bn = 0;
  endtask

  task automatic model_beat(input bit v, input logic [7:0] d, input bit sop, input bit eop, input bit last);
    logic [MB-1:0] vec;
    if (v) begin
      m_idle = 0;
      if (sop) begin
        if (m_in_msg) m_frm = 1;
        m_cur.delete();
        m_cur.push_back(d);
        m_in_msg = 1;
      end else if (m_in_msg) begin
        if (m_cur.size() < NB) m_cur.push_back(d);
        else m_ovf = 1;
      end
      if (m_in_msg && eop) begin
        vec = '0;
        for (int i = 0; i < m_cur.size(); i++) vec[MB-1-8*i -: 8] = m_cur[i];
        m_bm[m_bn] = vec;
        m_bc[m_bn] = exp_code(m_cur[0]);
        m_bn++;
        m_in_msg = 0;
        if (last || m_bn == 3) model_emit();
      end
    end else begin
`ifdef STAGE4_FLUSH_TIMEOUT_EN
      if (!m_in_msg && m_bn > 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          model_emit();
          m_idle = 0;
        end
      end
`endif
    end
  endtask

  task automatic chk_v(input string nm, input logic [MB-1:0] act, input logic [MB-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic beat(input bit v, input logic [7:0] d, input bit sop, input bit eop, input bit last);
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_sop = sop; in_eop = eop; in_last = last;
    model_beat(v, d, sop, eop, last);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [63:0] w, input int len, input bit last);
    for (int i = 0; i < len; i++)
      beat(1'b1, w[8*(len-1-i) +: 8], i == 0, i == len - 1, (i == len - 1) ? last : 1'b0);
  endtask

  task automatic send_msg(input logic [7:0] t, input int len, input bit last, input int gap);
    for (int i = 0; i < len; i++) begin
      beat(1'b1, (i == 0) ? t : 8'($urandom), i == 0, i == len - 1,
           (i == len - 1) ? last : 1'($urandom));
      if (gap > 0 && i != len - 1) idle($urandom_range(0, gap));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_i({tag, "_en"}, int'(message_en), 0);
    chk_v({tag, "_m1"}, message_1, '0);
    chk_v({tag, "_m2"}, message_2, '0);
    chk_v({tag, "_m3"}, message_3, '0);
    chk_i({tag, "_c1"}, int'(message_mux_control_m1), 0);
    chk_i({tag, "_c2"}, int'(message_mux_control_m2), 0);
    chk_i({tag, "_c3"}, int'(message_mux_control_m3), 0);
    chk_i({tag, "_ovf"}, int'(overflow_err), 0);
    chk_i({tag, "_frm"}, int'(framing_err), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && message_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_strobe: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk_i("strobe_cycle", cyc, e.cyc);
        chk_v("lane1_msg", message_1, e.m[0]);
        chk_v("lane2_msg", message_2, e.m[1]);
        chk_v("lane3_msg", message_3, e.m[2]);
        chk_i("lane1_ctrl", int'(message_mux_control_m1), int'(e.c[0]));
        chk_i("lane2_ctrl", int'(message_mux_control_m2), int'(e.c[1]));
        chk_i("lane3_ctrl", int'(message_mux_control_m3), int'(e.c[2]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Three messages fill a batch without in_last.
    send_word(64'h6B1122, 3, 1'b0);
    send_word(64'h41A0B0, 3, 1'b0);
    send_word(64'h45C0, 2, 1'b0);
    idle(3);
    chk_v("t1_m1_top", MB'(message_1[MB-1 -: 24]), MB'(24'h6B1122));

    // Single message closed by in_last.
    send_word(64'h6BAA, 2, 1'b1);
    idle(3);

    // Oversized message keeps the first NB bytes.
    send_msg(8'h41, 70, 1'b1, 0);
    idle(3);
    chk_i("t3_overflow", int'(overflow_err), 1);
    chk_i("t3_ctrl", int'(message_mux_control_m1), 2);

    // Restart mid-message.
    beat(1'b1, 8'h6B, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 8'h45, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    idle(3);
    chk_i("t4_framing", int'(framing_err), 1);
    chk_v("t4_m1_top", MB'(message_1[MB-1 -: 16]), MB'(16'h4501));

    // Reset while filling lane 2.
    send_word(64'h6B22, 2, 1'b0);
    beat(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("inreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(64'h6B, 1, 1'b1);
    idle(3);
    chk_v("t5_m2_clean", message_2, '0);

    // Partial batch left idle: flushed only with the timeout feature.
    send_word(64'h41B2, 2, 1'b0);
    idle(300);

    for (int n = 0; n < 80; n++) begin
      logic [7:0] t;
      int         kind;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0:       t = 8'h6B;
        1:       t = 8'h41;
        2:       t = 8'h45;
        3:       t = 8'h00;
        default: t = 8'($urandom);
      endcase
      if (kind == 0) begin
        beat(1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      end else if (kind == 1) begin
        send_msg(t, $urandom_range(2, 4), 1'b0, 0);
        beat(1'b1, t, 1'b1, 1'b0, 1'b0);
        beat(1'b1, 8'($urandom), 1'b0, 1'b1, 1'($urandom));
      end else if (kind == 2) begin
        send_msg(t, $urandom_range(65, 68), $urandom_range(0, 3) == 0, 1);
      end else begin
        send_msg(t, $urandom_range(1, 8), $urandom_range(0, 3) == 0, 1);
      end
      idle($urandom_range(0, 2));
    end
    send_word(64'h45, 1, 1'b1);
    idle(5);
    chk_i("final_overflow", int'(overflow_err), int'(m_ovf));
    chk_i("final_framing", int'(framing_err), int'(m_frm));
    chk_i("pending_batches", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
